hsid_x_read_seq: RTL and testbench
==================================

HSID_X_READ_SEQ -- requirements
Module: hsid_x_read_seq

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default HSID_WORD_WIDTH, OBI word width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default HSID_DATA_WIDTH, band sample width; WORD_WIDTH/DATA_WIDTH is a power of two, at least 1.
REQ-003 SHALL have parameter HSP_BANDS_WIDTH, default HSID_HSP_BANDS_WIDTH, band-count width.
REQ-004 SHALL have parameter HSP_LIBRARY_WIDTH, default HSID_HSP_LIBRARY_WIDTH, library-size width.
REQ-005 SHALL have parameter LIMIT_WIDTH, default HSP_BANDS_WIDTH+HSP_LIBRARY_WIDTH, obi_limit_in width.
REQ-006 SHALL have parameter MAX_BURST, default 64, maximum words per OBI transaction when chunking is enabled.
REQ-007 SHALL have ports clk (input, 1, clock) and rst (input, 1, reset); one clock; reset is synchronous and active-high.
REQ-008 SHALL have inputs pixel_bands [HSP_BANDS_WIDTH], library_size [HSP_LIBRARY_WIDTH], captured_pixel_addr [WORD_WIDTH], library_pixel_addr [WORD_WIDTH], start (1), clear (1).
REQ-009 SHALL have OBI-side ports: obi_initial_addr output [WORD_WIDTH]; obi_limit_in output [LIMIT_WIDTH]; obi_start output (1); obi_done input (1); obi_error input (1).
REQ-010 SHALL have status outputs busy (1), done (1, pulse), error (1, sticky), lib_words_left output [LIMIT_WIDTH].

Function
REQ-011 SHALL compute packs = ceil(pixel_bands / (WORD_WIDTH/DATA_WIDTH)); odd band counts round up.
REQ-012 SHALL compute total library words = packs * library_size at full product width, with no truncation before the range check.
REQ-013 SHALL sample all configuration inputs on the accepted start cycle only; later changes are ignored until the next run.
REQ-014 SHALL implement the states IDLE, START_CAPT, READ_CAPT, START_LIB, READ_LIB, DONE and ERR.
REQ-015 IDLE: on start=1 with clear=0, SHALL go to ERR if packs==0, library_size==0, or the total exceeds 2^LIMIT_WIDTH-1; otherwise SHALL go to START_CAPT.
REQ-016 START_CAPT: SHALL drive obi_initial_addr=captured_pixel_addr, obi_limit_in=packs, and obi_start=1 for exactly one cycle, then go to READ_CAPT.
REQ-017 READ_CAPT: on obi_done SHALL go to START_LIB.
REQ-018 START_LIB: SHALL drive obi_initial_addr=current library address, obi_limit_in=current chunk size, and a one-cycle obi_start pulse, then go to READ_LIB.
REQ-019 READ_LIB: on obi_done, SHALL decrement lib_words_left by the chunk size and advance the address by chunk*WORD_WIDTH/8 (modulo 2^WORD_WIDTH); if lib_words_left becomes 0 SHALL go to DONE, else to START_LIB.
REQ-020 DONE: SHALL assert done for one cycle, then go to IDLE.
REQ-021 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored.
REQ-022 obi_error=1 in READ_CAPT or READ_LIB SHALL take priority over obi_done on the same cycle and SHALL go to ERR.
REQ-023 ERR: SHALL set error=1 and go to IDLE on the next cycle; error SHALL remain 1 until clear or the next accepted start.
REQ-024 obi_done and obi_error outside the READ states SHALL be ignored.
REQ-025 clear=1 in any state SHALL, on the next edge, force IDLE, clear error, and set obi_start=0 and lib_words_left=0 with no done pulse; clear SHALL win over a simultaneous start.
REQ-026 obi_initial_addr and obi_limit_in SHALL hold their last values except when START_CAPT or START_LIB updates them.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 On rst=1 at a clk edge: state=IDLE; obi_initial_addr=0; obi_limit_in=1; obi_start=0; busy=0; done=0; error=0; lib_words_left=0.
REQ-029 rst mid-transaction SHALL abandon the run immediately; a pending obi_done after reset SHALL be ignored.

Configuration
REQ-030 With macro HSID_X_READ_SEQ_CHUNK_EN defined, the library chunk size SHALL be min(lib_words_left, MAX_BURST), and the read SHALL span ceil(total/MAX_BURST) OBI transactions.
REQ-031 Without HSID_X_READ_SEQ_CHUNK_EN, the chunk size SHALL be the full total: exactly one library transaction, and MAX_BURST is unused.

Verification
REQ-032 Basic run, chunking off: WORD=32, DATA=16, bands=8, lib=4, capt=0x1000, libaddr=0x2000 -> (0x1000, limit 4), then (0x2000, limit 16), done pulse, busy back to 0.
REQ-033 Odd bands, chunking on: bands=7, lib=20, MAX_BURST=64 -> packs=4, total=80 -> lib transactions (0x2000, 64) then (0x2100, 16).
REQ-034 Bad configuration: bands=0 or lib=0 -> no obi_start, error=1 the cycle after ERR, busy=0.
REQ-035 obi_error and obi_done together in READ_LIB -> error=1, no done pulse, no further obi_start.
REQ-036 clear and start on the same cycle in IDLE -> stays IDLE; clear during READ_LIB -> IDLE next cycle, a late obi_done is ignored.
REQ-037 rst during READ_CAPT -> all outputs at reset values next cycle; a fresh start then runs normally.

Source files
------------

// File: rtl/hsid_x_read_seq.sv
// Sequences one captured-pixel OBI read followed by the library read, optionally split into MAX_BURST chunks.
// Optional feature macro: HSID_X_READ_SEQ_CHUNK_EN (library read chunked into MAX_BURST-word transactions).
`ifndef HSID_WORD_WIDTH
`define HSID_WORD_WIDTH 32
`endif
`ifndef HSID_DATA_WIDTH
`define HSID_DATA_WIDTH 16
`endif
`ifndef HSID_HSP_BANDS_WIDTH
`define HSID_HSP_BANDS_WIDTH 8
`endif
`ifndef HSID_HSP_LIBRARY_WIDTH
`define HSID_HSP_LIBRARY_WIDTH 8
`endif

module hsid_x_read_seq #(
    parameter int WORD_WIDTH        = `HSID_WORD_WIDTH,
    parameter int DATA_WIDTH        = `HSID_DATA_WIDTH,
    parameter int HSP_BANDS_WIDTH   = `HSID_HSP_BANDS_WIDTH,
    parameter int HSP_LIBRARY_WIDTH = `HSID_HSP_LIBRARY_WIDTH,
    parameter int LIMIT_WIDTH       = HSP_BANDS_WIDTH + HSP_LIBRARY_WIDTH,
    parameter int MAX_BURST         = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [HSP_BANDS_WIDTH-1:0]   pixel_bands,
    input  logic [HSP_LIBRARY_WIDTH-1:0] library_size,
    input  logic [WORD_WIDTH-1:0]        captured_pixel_addr,
    input  logic [WORD_WIDTH-1:0]        library_pixel_addr,
    input  logic                         start,
    input  logic                         clear,
    output logic [WORD_WIDTH-1:0]        obi_initial_addr,
    output logic [LIMIT_WIDTH-1:0]       obi_limit_in,
    output logic                         obi_start,
    input  logic                         obi_done,
    input  logic                         obi_error,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [LIMIT_WIDTH-1:0]       lib_words_left
);

    // state      | meaning
    // IDLE       | waiting for start; START_CAPT/START_LIB pulse obi_start
    // READ_CAPT  | captured pixel read in flight; READ_LIB library chunk in flight
    // DONE / ERR | one-cycle completion pulse / error latch, then IDLE
    typedef enum logic [2:0] {
        IDLE, START_CAPT, READ_CAPT, START_LIB, READ_LIB, DONE, ERR
    } state_e;

`ifdef HSID_X_READ_SEQ_CHUNK_EN
    localparam bit CHUNK_EN = 1'b1;
`else
    localparam bit CHUNK_EN = 1'b0;
`endif

    localparam int RATIO      = WORD_WIDTH / DATA_WIDTH;
    localparam int RATIO_LOG2 = (RATIO > 1) ? $clog2(RATIO) : 0;
    localparam int PROD_WIDTH = HSP_BANDS_WIDTH + HSP_LIBRARY_WIDTH;
    localparam int CMP_WIDTH  = ((PROD_WIDTH > LIMIT_WIDTH) ? PROD_WIDTH : LIMIT_WIDTH) + 1;
    localparam logic [CMP_WIDTH-1:0] LIMIT_MAX = (CMP_WIDTH'(1) << LIMIT_WIDTH) - CMP_WIDTH'(1);

    state_e                   state_q, state_d;
    logic [WORD_WIDTH-1:0]    obi_initial_addr_q, obi_initial_addr_d;
    logic [LIMIT_WIDTH-1:0]   obi_limit_in_q, obi_limit_in_d;
    logic                     obi_start_q, obi_start_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;
    logic [LIMIT_WIDTH-1:0]   lib_words_left_q, lib_words_left_d;
    logic [WORD_WIDTH-1:0]    lib_addr_q, lib_addr_d;

    logic [HSP_BANDS_WIDTH:0] packs;
    logic [PROD_WIDTH-1:0]    total;
    logic                     cfg_bad;
    logic [LIMIT_WIDTH-1:0]   left_next;
    logic [WORD_WIDTH-1:0]    lib_addr_next;

    function automatic logic [LIMIT_WIDTH-1:0] chunk_of(input logic [LIMIT_WIDTH-1:0] left);
        if (CHUNK_EN && (32'(left) > 32'(MAX_BURST)))
            return LIMIT_WIDTH'(MAX_BURST);
        return left;
    endfunction

    // Extra MSB keeps the round-up add from overflowing on the widest band count.
    assign packs = ({1'b0, pixel_bands} + (HSP_BANDS_WIDTH+1)'(RATIO - 1)) >> RATIO_LOG2;
    assign total = PROD_WIDTH'(packs) * PROD_WIDTH'(library_size);
    assign cfg_bad = (packs == '0) || (library_size == '0) || (CMP_WIDTH'(total) > LIMIT_MAX);
    assign left_next = lib_words_left_q - obi_limit_in_q;
    assign lib_addr_next = lib_addr_q
                         + WORD_WIDTH'(obi_limit_in_q) * WORD_WIDTH'(WORD_WIDTH / 8);

    always_comb begin
        state_d            = state_q;
        obi_initial_addr_d = obi_initial_addr_q;
        obi_limit_in_d     = obi_limit_in_q;
        obi_start_d        = 1'b0;
        done_d             = 1'b0;
        error_d            = error_q;
        lib_words_left_d   = lib_words_left_q;
        lib_addr_d         = lib_addr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    if (cfg_bad) begin
                        state_d          = ERR;
                        lib_words_left_d = '0;
                    end else begin
                        state_d            = START_CAPT;
                        obi_initial_addr_d = captured_pixel_addr;
                        obi_limit_in_d     = LIMIT_WIDTH'(packs);
                        obi_start_d        = 1'b1;
                        lib_words_left_d   = LIMIT_WIDTH'(total);
                        lib_addr_d         = library_pixel_addr;
                    end
                end
            end
            START_CAPT: state_d = READ_CAPT;
            READ_CAPT: begin
                if (obi_error) begin
                    state_d = ERR;
                end else if (obi_done) begin
                    state_d            = START_LIB;
                    obi_initial_addr_d = lib_addr_q;
                    obi_limit_in_d     = chunk_of(lib_words_left_q);
                    obi_start_d        = 1'b1;
                end
            end
            START_LIB: state_d = READ_LIB;
            READ_LIB: begin
                if (obi_error) begin
                    state_d = ERR;
                end else if (obi_done) begin
                    lib_words_left_d = left_next;
                    lib_addr_d       = lib_addr_next;
                    if (left_next == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d            = START_LIB;
                        obi_initial_addr_d = lib_addr_next;
                        obi_limit_in_d     = chunk_of(left_next);
                        obi_start_d        = 1'b1;
                    end
                end
            end
            DONE: state_d = IDLE;
            ERR: begin
                state_d = IDLE;
                error_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d            = IDLE;
            obi_initial_addr_d = obi_initial_addr_q;
            obi_limit_in_d     = obi_limit_in_q;
            obi_start_d        = 1'b0;
            done_d             = 1'b0;
            error_d            = 1'b0;
            lib_words_left_d   = '0;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= IDLE;
            obi_initial_addr_q <= '0;
            obi_limit_in_q     <= LIMIT_WIDTH'(1);
            obi_start_q        <= 1'b0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            error_q            <= 1'b0;
            lib_words_left_q   <= '0;
            lib_addr_q         <= '0;
        end else begin
            state_q            <= state_d;
            obi_initial_addr_q <= obi_initial_addr_d;
            obi_limit_in_q     <= obi_limit_in_d;
            obi_start_q        <= obi_start_d;
            busy_q             <= busy_d;
            done_q             <= done_d;
            error_q            <= error_d;
            lib_words_left_q   <= lib_words_left_d;
            lib_addr_q         <= lib_addr_d;
        end
    end

    assign obi_initial_addr = obi_initial_addr_q;
    assign obi_limit_in     = obi_limit_in_q;
    assign obi_start        = obi_start_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;
    assign lib_words_left   = lib_words_left_q;

endmodule

// File: tb/tb_hsid_x_read_seq.sv
// Bench for hsid_x_read_seq: transaction-list model of each run, outputs compared every cycle.
module tb_hsid_x_read_seq;
    localparam int WW   = 32;
    localparam int DW   = 16;
    localparam int BW   = 8;
    localparam int LBW  = 8;
    localparam int LIMW = 12;
    localparam int MAXB = 64;
    localparam int R    = WW / DW;

    logic            clk = 1'b0;
    logic            rst;
    logic [BW-1:0]   pixel_bands;
    logic [LBW-1:0]  library_size;
    logic [WW-1:0]   captured_pixel_addr, library_pixel_addr;
    logic            start, clear, obi_done, obi_error;
    logic [WW-1:0]   obi_initial_addr;
    logic [LIMW-1:0] obi_limit_in, lib_words_left;
    logic            obi_start, busy, done, error;

    always #5 clk = ~clk;

    hsid_x_read_seq #(
        .WORD_WIDTH(WW), .DATA_WIDTH(DW), .HSP_BANDS_WIDTH(BW),
        .HSP_LIBRARY_WIDTH(LBW), .LIMIT_WIDTH(LIMW), .MAX_BURST(MAXB)
    ) dut (
        .clk(clk), .rst(rst), .pixel_bands(pixel_bands), .library_size(library_size),
        .captured_pixel_addr(captured_pixel_addr), .library_pixel_addr(library_pixel_addr),
        .start(start), .clear(clear), .obi_initial_addr(obi_initial_addr),
        .obi_limit_in(obi_limit_in), .obi_start(obi_start), .obi_done(obi_done),
        .obi_error(obi_error), .busy(busy), .done(done), .error(error),
        .lib_words_left(lib_words_left)
    );

    int checks = 0;
    int errors = 0;
    logic            e_busy, e_done, e_err, e_start;
    logic [WW-1:0]   e_addr;
    logic [LIMW-1:0] e_limit, e_left;
    logic [WW-1:0]   q_addr[$];
    int              q_len[$];
    logic [WW-1:0]   obs_addr[$];
    int              obs_len[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("error", error, e_err);
        chk("obi_start", obi_start, e_start);
        chk("obi_initial_addr", obi_initial_addr, e_addr);
        chk("obi_limit_in", obi_limit_in, e_limit);
        chk("lib_words_left", lib_words_left, e_left);
        if (obi_start === 1'b1) begin
            obs_addr.push_back(obi_initial_addr);
            obs_len.push_back(int'(obi_limit_in));
        end
    endtask

    function automatic int packs_of(input int b);
        return (b + R - 1) / R;
    endfunction

    function automatic int total_of(input int b, input int l);
        return packs_of(b) * l;
    endfunction

    function automatic bit cfg_bad(input int b, input int l);
        return (packs_of(b) == 0) || (l == 0) || (total_of(b, l) > (1 << LIMW) - 1);
    endfunction

    task automatic build_plan(input int b, input int l, input logic [WW-1:0] la);
        int rem;
        logic [WW-1:0] a;
        q_addr.delete();
        q_len.delete();
        rem = total_of(b, l);
        a = la;
        while (rem > 0) begin
            int c;
`ifdef HSID_X_READ_SEQ_CHUNK_EN
            c = (rem > MAXB) ? MAXB : rem;
`else
            c = rem;
`endif
            q_addr.push_back(a);
            q_len.push_back(c);
            a = a + WW'(c * (WW / 8));
            rem -= c;
        end
    endtask

    task automatic scramble();
        pixel_bands         = BW'($urandom);
        library_size        = LBW'($urandom);
        captured_pixel_addr = $urandom;
        library_pixel_addr  = $urandom;
    endtask

    task automatic idle_wait();
        repeat ($urandom_range(0, 3)) begin
            start = 1'($urandom);
            tick();
        end
    endtask

    task automatic do_err(input bit with_done);
        start = 1'b0;
        obi_error = 1'b1;
        obi_done = with_done;
        e_start = 1'b0;
        tick();
        obi_error = 1'b0;
        obi_done = 1'b0;
        e_busy = 1'b0;
        e_err = 1'b1;
        tick();
        tick();
    endtask

    // err_at/clr_at: 0 = capture read, k>=1 = k-th library transaction, -1 = never
    task automatic run(input int b, input int l, input logic [WW-1:0] ca,
                       input logic [WW-1:0] la, input int err_at, input int clr_at);
        bit bad;
        bad = cfg_bad(b, l);
        pixel_bands = BW'(b);
        library_size = LBW'(l);
        captured_pixel_addr = ca;
        library_pixel_addr = la;
        start = 1'b1;
        clear = 1'b0;
        e_busy = 1'b1;
        e_done = 1'b0;
        e_err = 1'b0;
        e_start = !bad;
        if (bad) begin
            e_left = '0;
        end else begin
            e_addr = ca;
            e_limit = LIMW'(packs_of(b));
            e_left = LIMW'(total_of(b, l));
        end
        tick();
        start = 1'b0;
        scramble();
        if (bad) begin
            e_busy = 1'b0;
            e_err = 1'b1;
            e_start = 1'b0;
            tick();
            tick();
            return;
        end
        e_start = 1'b0;
        obi_done = 1'($urandom);
        obi_error = 1'($urandom);
        start = 1'($urandom);
        tick();
        obi_done = 1'b0;
        obi_error = 1'b0;
        idle_wait();
        if (err_at == 0) begin
            do_err(1'($urandom));
            return;
        end
        build_plan(b, l, la);
        obi_done = 1'b1;
        e_start = 1'b1;
        e_addr = q_addr[0];
        e_limit = LIMW'(q_len[0]);
        tick();
        obi_done = 1'b0;
        for (int k = 0; k < q_len.size(); k++) begin
            e_start = 1'b0;
            obi_done = 1'($urandom);
            obi_error = 1'($urandom);
            tick();
            obi_done = 1'b0;
            obi_error = 1'b0;
            idle_wait();
            if (err_at == k + 1) begin
                do_err(1'b1);
                return;
            end
            if (clr_at == k + 1) begin
                clear = 1'b1;
                start = 1'($urandom);
                e_busy = 1'b0;
                e_start = 1'b0;
                e_left = '0;
                e_err = 1'b0;
                tick();
                clear = 1'b0;
                start = 1'b0;
                obi_done = 1'b1;
                tick();
                obi_done = 1'b0;
                return;
            end
            obi_done = 1'b1;
            e_left = e_left - LIMW'(q_len[k]);
            if (k == q_len.size() - 1) begin
                e_done = 1'b1;
                tick();
                obi_done = 1'b0;
                e_done = 1'b0;
                e_busy = 1'b0;
                start = 1'b0;
                tick();
            end else begin
                e_start = 1'b1;
                e_addr = q_addr[k + 1];
                e_limit = LIMW'(q_len[k + 1]);
                tick();
                obi_done = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int b, l, sel, ea, cl;
        rst = 1'b1;
        start = 1'b0;
        clear = 1'b0;
        obi_done = 1'b0;
        obi_error = 1'b0;
        pixel_bands = '0;
        library_size = '0;
        captured_pixel_addr = '0;
        library_pixel_addr = '0;
        e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_start = 1'b0;
        e_addr = '0; e_limit = LIMW'(1); e_left = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // basic run
        obs_addr.delete(); obs_len.delete();
        run(8, 4, 32'h1000, 32'h2000, -1, -1);
        chk("basic_txn_count", obs_addr.size(), 2);
        if (obs_addr.size() == 2) begin
            chk("basic_capt_addr", obs_addr[0], 32'h1000);
            chk("basic_capt_limit", obs_len[0], 4);
            chk("basic_lib_addr", obs_addr[1], 32'h2000);
            chk("basic_lib_limit", obs_len[1], 16);
        end

        // odd band count
        obs_addr.delete(); obs_len.delete();
        run(7, 20, 32'h1000, 32'h2000, -1, -1);
        chk("odd_capt_limit", obs_len.size() > 0 ? obs_len[0] : -1, 4);
`ifdef HSID_X_READ_SEQ_CHUNK_EN
        chk("odd_txn_count", obs_addr.size(), 3);
        if (obs_addr.size() == 3) begin
            chk("odd_lib0_addr", obs_addr[1], 32'h2000);
            chk("odd_lib0_limit", obs_len[1], 64);
            chk("odd_lib1_addr", obs_addr[2], 32'h2100);
            chk("odd_lib1_limit", obs_len[2], 16);
        end
`else
        chk("odd_txn_count", obs_addr.size(), 2);
        if (obs_addr.size() == 2) begin
            chk("odd_lib_addr", obs_addr[1], 32'h2000);
            chk("odd_lib_limit", obs_len[1], 80);
        end
`endif

        // bad configurations: zero bands, zero library, over-range total
        obs_addr.delete(); obs_len.delete();
        run(0, 5, 32'h1000, 32'h2000, -1, -1);
        run(6, 0, 32'h1000, 32'h2000, -1, -1);
        run(255, 255, 32'h1000, 32'h2000, -1, -1);
        chk("badcfg_no_start", obs_addr.size(), 0);

        // error together with done in the first library read
        obs_addr.delete(); obs_len.delete();
        run(8, 4, 32'h1000, 32'h2000, 1, -1);
        chk("lib_err_txn_count", obs_addr.size(), 2);

        // clear and start together in IDLE while error is set
        pixel_bands = 8'd8; library_size = 8'd4;
        start = 1'b1; clear = 1'b1;
        e_busy = 1'b0; e_err = 1'b0; e_start = 1'b0; e_left = '0;
        tick();
        start = 1'b0; clear = 1'b0;
        tick();

        // clear during the library read
        run(8, 4, 32'h1000, 32'h2000, -1, 1);

        // reset during the capture read
        pixel_bands = 8'd8; library_size = 8'd4;
        captured_pixel_addr = 32'h1000; library_pixel_addr = 32'h2000;
        start = 1'b1;
        e_busy = 1'b1; e_err = 1'b0; e_start = 1'b1; e_done = 1'b0;
        e_addr = 32'h1000; e_limit = LIMW'(4); e_left = LIMW'(16);
        tick();
        start = 1'b0; e_start = 1'b0;
        tick();
        tick();
        rst = 1'b1; obi_done = 1'b1;
        e_busy = 1'b0; e_addr = '0; e_limit = LIMW'(1); e_left = '0;
        tick();
        rst = 1'b0;
        tick();
        obi_done = 1'b0;
        tick();
        run(8, 4, 32'h1000, 32'h2000, -1, -1);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                b = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 40);
                l = (b == 0) ? $urandom_range(0, 60) : 0;
            end else if (sel == 1) begin
                b = $urandom_range(200, 255);
                l = $urandom_range(200, 255);
            end else begin
                b = $urandom_range(1, 40);
                l = $urandom_range(1, 60);
            end
            ea = ($urandom_range(0, 6) == 0) ? $urandom_range(0, 8) : -1;
            cl = ($urandom_range(0, 6) == 0) ? $urandom_range(1, 8) : -1;
            run(b, l, $urandom, $urandom, ea, cl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
